es_sequencer: RTL and testbench

- Command sequencer that sits directly upstream of ex_stack (the 32-entry, 16-bit expression stack).
- Accepts one decoded stack command at a time over a valid/ready handshake and drives the ex_stack control strobes (pushVal, popNum, dupNum, ESOp, ESAct).
- Keeps an authoritative depth count and rejects overflow/underflow before they reach the stack.
- Sequences multi-step ALU ops: BINOP pops two operands and pushes the ALU result; UNOP pops one and pushes the result.

---
 rtl/es_pkg.sv | 31 +++
 rtl/es_depth_chk.sv | 54 +++++
 rtl/es_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_es_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/es_pkg.sv
// es_pkg: shared definitions for the ex_stack command sequencer.
//   - cmdOp encodings (ES_CMD_*)
//   - ex_stack ESOp encodings (ES_OP_*)
//   - sequencer FSM state type
//   - default stack width/depth
package es_pkg;

    localparam int ES_WIDTH = 16;
    localparam int ES_DEPTH = 32;

    localparam logic [2:0] ES_CMD_NOP   = 3'd0;
    localparam logic [2:0] ES_CMD_PUSH  = 3'd1;
    localparam logic [2:0] ES_CMD_POP   = 3'd2;
    localparam logic [2:0] ES_CMD_DUP   = 3'd3;
    localparam logic [2:0] ES_CMD_BINOP = 3'd4;
    localparam logic [2:0] ES_CMD_UNOP  = 3'd5;

    localparam logic [1:0] ES_OP_PUSH = 2'd0;
    localparam logic [1:0] ES_OP_POP  = 2'd1;
    localparam logic [1:0] ES_OP_DUP  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACT,
        ST_SETTLE,
        ST_POPOP,
        ST_SETTLE_P,
        ST_PUSHR
    } esState_t;

endpackage

// File: rtl/es_depth_chk.sv
// es_depth_chk: combinational legality check of a stack command against the
// current occupancy.
//   depth : current occupancy (0..DEPTH)
//   op    : command opcode (ES_CMD_*)
//   cnt   : POP count-1 (bit 0 only) / DUP items-1
//   ok    : command may be issued
//   ovf   : command would overflow the stack
//   unf   : command would underflow the stack
// NOP and reserved opcodes are always ok (they never touch the stack).
module es_depth_chk
    import es_pkg::*;
#(
    parameter int DEPTH = ES_DEPTH,
    parameter int DW    = $clog2(ES_DEPTH) + 1
) (
    input  logic [DW-1:0] depth,
    input  logic [2:0]    op,
    input  logic [1:0]    cnt,
    output logic          ok,
    output logic          ovf,
    output logic          unf
);

    localparam logic [DW:0] DEPTH_X = (DW+1)'(DEPTH);

    // One extra bit so depth+cnt+1 cannot wrap before the compare.
    logic [DW:0] depthX;
    logic [DW:0] dupNeed;
    logic [DW:0] popNeed;

    always_comb begin
        depthX  = {1'b0, depth};
        dupNeed = (DW+1)'(cnt) + (DW+1)'(1);
        popNeed = (DW+1)'(cnt[0]) + (DW+1)'(1);
        ovf     = 1'b0;
        unf     = 1'b0;
        case (op)
            ES_CMD_PUSH:  ovf = (depthX == DEPTH_X);
            ES_CMD_POP:   unf = (depthX < popNeed);
            ES_CMD_DUP: begin
                if (depthX < dupNeed) begin
                    unf = 1'b1;
                end else if ((depthX + dupNeed) > DEPTH_X) begin
                    ovf = 1'b1;
                end
            end
            ES_CMD_BINOP: unf = (depthX < (DW+1)'(2));
            ES_CMD_UNOP:  unf = (depthX < (DW+1)'(1));
            default: ;
        endcase
        ok = !ovf && !unf;
    end

endmodule

// File: rtl/es_sequencer.sv
// es_sequencer: accepts one decoded stack command at a time (valid/ready) and
// drives the ex_stack control strobes, tracking stack depth and rejecting
// overflow/underflow. BINOP/UNOP are sequenced as pop, settle, push result.
//   clk, rst_n          : clock, async active-low reset
//   cmdValid/cmdReady   : command handshake (ready only in IDLE)
//   cmdOp/cmdImm/cmdCnt : command opcode, PUSH value, POP/DUP count-1
//   aluResult           : ALU result from ex_stack outA/outB, captured at accept
//   pushVal/popNum/dupNum/ESOp/ESAct : ex_stack controls (ESAct = 1-cycle strobe)
//   depth               : stack occupancy
//   errOvf/errUnf       : sticky error flags, errClr clears both
//
// state       | meaning
// ------------+-----------------------------------------------
// ST_IDLE     | ready for a command
// ST_ACT      | push/pop/dup strobe on ESAct
// ST_SETTLE   | waiting for ex_stack outputs after a strobe
// ST_POPOP    | operand pop strobe of BINOP/UNOP
// ST_SETTLE_P | settling after operand pop
// ST_PUSHR    | ALU result push strobe
module es_sequencer
    import es_pkg::*;
#(
    parameter int WIDTH  = ES_WIDTH,
    parameter int DEPTH  = ES_DEPTH,
    parameter int SETTLE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmdValid,
    output logic                     cmdReady,
    input  logic [2:0]               cmdOp,
    input  logic [WIDTH-1:0]         cmdImm,
    input  logic [1:0]               cmdCnt,
    input  logic [WIDTH-1:0]         aluResult,
    output logic [WIDTH-1:0]         pushVal,
    output logic                     popNum,
    output logic [1:0]               dupNum,
    output logic [1:0]               ESOp,
    output logic                     ESAct,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     errOvf,
    output logic                     errUnf,
    input  logic                     errClr
);

    localparam int DW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

    esState_t         state, stateNext;
    logic [SW-1:0]    settleCnt, settleCntNext;
    logic [WIDTH-1:0] aluCap, aluCapNext;
    logic [WIDTH-1:0] pushValNext;
    logic             popNumNext;
    logic [1:0]       dupNumNext;
    logic [1:0]       esOpNext;
    logic             esActNext;
    logic [DW-1:0]    depthNext;
    logic             errOvfNext, errUnfNext;
    logic             newOvf, newUnf;
    logic             chkOk, chkOvf, chkUnf;

    es_depth_chk #(.DEPTH(DEPTH), .DW(DW)) uDepthChk (
        .depth (depth),
        .op    (cmdOp),
        .cnt   (cmdCnt),
        .ok    (chkOk),
        .ovf   (chkOvf),
        .unf   (chkUnf)
    );

    assign cmdReady = (state == ST_IDLE);

    // Strobe outputs and depth are registered together, so depth moves on the
    // same edge that raises ESAct.
    always_comb begin
        stateNext     = state;
        settleCntNext = settleCnt;
        aluCapNext    = aluCap;
        pushValNext   = pushVal;
        popNumNext    = popNum;
        dupNumNext    = dupNum;
        esOpNext      = ESOp;
        esActNext     = 1'b0;
        depthNext     = depth;
        newOvf        = 1'b0;
        newUnf        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmdValid) begin
                    aluCapNext = aluResult;
                    if (!chkOk) begin
                        newOvf = chkOvf;
                        newUnf = chkUnf;
                    end else begin
                        case (cmdOp)
                            ES_CMD_PUSH: begin
                                stateNext   = ST_ACT;
                                esActNext   = 1'b1;
                                esOpNext    = ES_OP_PUSH;
                                pushValNext = cmdImm;
                                depthNext   = depth + DW'(1);
                            end
                            ES_CMD_POP: begin
                                stateNext  = ST_ACT;
                                esActNext  = 1'b1;
                                esOpNext   = ES_OP_POP;
                                popNumNext = cmdCnt[0];
                                depthNext  = depth - DW'(cmdCnt[0]) - DW'(1);
                            end
                            ES_CMD_DUP: begin
                                stateNext  = ST_ACT;
                                esActNext  = 1'b1;
                                esOpNext   = ES_OP_DUP;
                                dupNumNext = cmdCnt;
                                depthNext  = depth + DW'(cmdCnt) + DW'(1);
                            end
                            ES_CMD_BINOP: begin
                                stateNext  = ST_POPOP;
                                esActNext  = 1'b1;
                                esOpNext   = ES_OP_POP;
                                popNumNext = 1'b1;
                                depthNext  = depth - DW'(2);
                            end
                            ES_CMD_UNOP: begin
                                stateNext  = ST_POPOP;
                                esActNext  = 1'b1;
                                esOpNext   = ES_OP_POP;
                                popNumNext = 1'b0;
                                depthNext  = depth - DW'(1);
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_ACT: begin
                stateNext     = ST_SETTLE;
                settleCntNext = SETTLE_LOAD;
            end
            ST_SETTLE: begin
                if (settleCnt == '0) begin
                    stateNext = ST_IDLE;
                end else begin
                    settleCntNext = settleCnt - SW'(1);
                end
            end
            ST_POPOP: begin
                stateNext     = ST_SETTLE_P;
                settleCntNext = SETTLE_LOAD;
            end
            ST_SETTLE_P: begin
                if (settleCnt == '0) begin
                    stateNext   = ST_PUSHR;
                    esActNext   = 1'b1;
                    esOpNext    = ES_OP_PUSH;
                    pushValNext = aluCap;
                    depthNext   = depth + DW'(1);
                end else begin
                    settleCntNext = settleCnt - SW'(1);
                end
            end
            ST_PUSHR: begin
                stateNext     = ST_SETTLE;
                settleCntNext = SETTLE_LOAD;
            end
            default: stateNext = ST_IDLE;
        endcase
        // A new error in the same cycle as errClr keeps the flag set.
        errOvfNext = (errOvf && !errClr) || newOvf;
        errUnfNext = (errUnf && !errClr) || newUnf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            settleCnt <= '0;
            aluCap    <= '0;
            pushVal   <= '0;
            popNum    <= 1'b0;
            dupNum    <= '0;
            ESOp      <= ES_OP_PUSH;
            ESAct     <= 1'b0;
            depth     <= '0;
            errOvf    <= 1'b0;
            errUnf    <= 1'b0;
        end else begin
            state     <= stateNext;
            settleCnt <= settleCntNext;
            aluCap    <= aluCapNext;
            pushVal   <= pushValNext;
            popNum    <= popNumNext;
            dupNum    <= dupNumNext;
            ESOp      <= esOpNext;
            ESAct     <= esActNext;
            depth     <= depthNext;
            errOvf    <= errOvfNext;
            errUnf    <= errUnfNext;
        end
    end

endmodule

// File: tb/tb_es_sequencer.sv
module tb_es_sequencer;
    import es_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic [2:0]  cmdOp = 3'd0;
    logic [15:0] cmdImm = 16'd0;
    logic [1:0]  cmdCnt = 2'd0;
    logic [15:0] aluResult = 16'd0;
    logic [15:0] pushVal;
    logic        popNum;
    logic [1:0]  dupNum;
    logic [1:0]  ESOp;
    logic        ESAct;
    logic [5:0]  depth;
    logic        errOvf;
    logic        errUnf;
    logic        errClr = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    es_sequencer #(.WIDTH(16), .DEPTH(32), .SETTLE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmdValid  (cmdValid),
        .cmdReady  (cmdReady),
        .cmdOp     (cmdOp),
        .cmdImm    (cmdImm),
        .cmdCnt    (cmdCnt),
        .aluResult (aluResult),
        .pushVal   (pushVal),
        .popNum    (popNum),
        .dupNum    (dupNum),
        .ESOp      (ESOp),
        .ESAct     (ESAct),
        .depth     (depth),
        .errOvf    (errOvf),
        .errUnf    (errUnf),
        .errClr    (errClr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one command for exactly one accepting edge; returns #1 after it.
    task automatic sendCmd(input logic [2:0] op, input logic [15:0] imm,
                           input logic [1:0] cnt, input logic [15:0] alu);
        @(negedge clk);
        cmdValid  = 1'b1;
        cmdOp     = op;
        cmdImm    = imm;
        cmdCnt    = cnt;
        aluResult = alu;
        @(posedge clk);
        #1;
        cmdValid = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (cmdReady) break;
            step();
        end
        chk(tag, 32'(cmdReady), 32'd1);
    endtask

    task automatic pulseClr();
        @(negedge clk);
        errClr = 1'b1;
        @(posedge clk);
        #1;
        errClr = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_ready", 32'(cmdReady), 32'd1);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_esact", 32'(ESAct), 32'd0);
        chk("rst_pushval", 32'(pushVal), 32'd0);
        chk("rst_errovf", 32'(errOvf), 32'd0);
        chk("rst_errunf", 32'(errUnf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First PUSH and its latency
        sendCmd(ES_CMD_PUSH, 16'd1, 2'd0, 16'd0);
        chk("push1_esact_n1", 32'(ESAct), 32'd1);
        chk("push1_esop", 32'(ESOp), 32'(ES_OP_PUSH));
        chk("push1_val", 32'(pushVal), 32'd1);
        chk("push1_depth", 32'(depth), 32'd1);
        chk("push1_ready_n1", 32'(cmdReady), 32'd0);
        step();
        chk("push1_esact_n2", 32'(ESAct), 32'd0);
        chk("push1_ready_n2", 32'(cmdReady), 32'd0);
        step();
        chk("push1_ready_n3", 32'(cmdReady), 32'd1);

        // Fill to 32, then overflowing PUSH
        for (int v = 2; v <= 32; v++) begin
            sendCmd(ES_CMD_PUSH, 16'(v), 2'd0, 16'd0);
            chk("fill_val", 32'(pushVal), 32'(v));
            waitIdle("fill_idle");
        end
        chk("fill_depth", 32'(depth), 32'd32);
        sendCmd(ES_CMD_PUSH, 16'd33, 2'd0, 16'd0);
        chk("ovf_esact", 32'(ESAct), 32'd0);
        chk("ovf_flag", 32'(errOvf), 32'd1);
        chk("ovf_depth", 32'(depth), 32'd32);
        chk("ovf_ready", 32'(cmdReady), 32'd1);

        // POP 2, DUP 2, then overflowing DUP with errClr in the same cycle
        sendCmd(ES_CMD_POP, 16'd0, 2'd1, 16'd0);
        chk("pop2_esact", 32'(ESAct), 32'd1);
        chk("pop2_esop", 32'(ESOp), 32'(ES_OP_POP));
        chk("pop2_popnum", 32'(popNum), 32'd1);
        chk("pop2_depth", 32'(depth), 32'd30);
        waitIdle("pop2_idle");
        sendCmd(ES_CMD_DUP, 16'd0, 2'd1, 16'd0);
        chk("dup2_esact", 32'(ESAct), 32'd1);
        chk("dup2_esop", 32'(ESOp), 32'(ES_OP_DUP));
        chk("dup2_dupnum", 32'(dupNum), 32'd1);
        chk("dup2_depth", 32'(depth), 32'd32);
        waitIdle("dup2_idle");
        pulseClr();
        chk("clr_ovf", 32'(errOvf), 32'd0);
        @(negedge clk);
        errClr = 1'b1;
        sendCmd(ES_CMD_DUP, 16'd0, 2'd0, 16'd0);
        errClr = 1'b0;
        chk("dupovf_esact", 32'(ESAct), 32'd0);
        chk("dupovf_flag", 32'(errOvf), 32'd1);
        chk("dupovf_depth", 32'(depth), 32'd32);

        // Drain to empty, BINOP underflow, clear
        for (int i = 0; i < 16; i++) begin
            sendCmd(ES_CMD_POP, 16'd0, 2'd1, 16'd0);
            waitIdle("drain_idle");
        end
        chk("drain_depth", 32'(depth), 32'd0);
        sendCmd(ES_CMD_BINOP, 16'd0, 2'd0, 16'd0);
        chk("binunf_esact", 32'(ESAct), 32'd0);
        chk("binunf_flag", 32'(errUnf), 32'd1);
        chk("binunf_depth", 32'(depth), 32'd0);
        pulseClr();
        chk("clr2_ovf", 32'(errOvf), 32'd0);
        chk("clr2_unf", 32'(errUnf), 32'd0);

        // BINOP from depth 2
        sendCmd(ES_CMD_PUSH, 16'd5, 2'd0, 16'd0);
        waitIdle("b_push5_idle");
        sendCmd(ES_CMD_PUSH, 16'd6, 2'd0, 16'd0);
        waitIdle("b_push6_idle");
        sendCmd(ES_CMD_BINOP, 16'd0, 2'd0, 16'h0007);
        aluResult = 16'h0099;
        chk("bin_n1_esact", 32'(ESAct), 32'd1);
        chk("bin_n1_esop", 32'(ESOp), 32'(ES_OP_POP));
        chk("bin_n1_popnum", 32'(popNum), 32'd1);
        chk("bin_n1_depth", 32'(depth), 32'd0);
        step();
        chk("bin_n2_esact", 32'(ESAct), 32'd0);
        step();
        chk("bin_n3_esact", 32'(ESAct), 32'd1);
        chk("bin_n3_esop", 32'(ESOp), 32'(ES_OP_PUSH));
        chk("bin_n3_val", 32'(pushVal), 32'h0007);
        chk("bin_n3_depth", 32'(depth), 32'd1);
        step();
        chk("bin_n4_ready", 32'(cmdReady), 32'd0);
        step();
        chk("bin_n5_ready", 32'(cmdReady), 32'd1);

        // UNOP from depth 1
        sendCmd(ES_CMD_UNOP, 16'd0, 2'd0, 16'h1234);
        chk("un_n1_popnum", 32'(popNum), 32'd0);
        chk("un_n1_depth", 32'(depth), 32'd0);
        step();
        step();
        chk("un_n3_esact", 32'(ESAct), 32'd1);
        chk("un_n3_val", 32'(pushVal), 32'h1234);
        chk("un_n3_depth", 32'(depth), 32'd1);
        waitIdle("un_idle");

        // NOP accepted with no strobe
        sendCmd(ES_CMD_NOP, 16'd0, 2'd0, 16'd0);
        chk("nop_esact", 32'(ESAct), 32'd0);
        chk("nop_ready", 32'(cmdReady), 32'd1);

        // Reset during SETTLE_P of a BINOP
        sendCmd(ES_CMD_PUSH, 16'd9, 2'd0, 16'd0);
        waitIdle("r_push_idle");
        sendCmd(ES_CMD_BINOP, 16'd0, 2'd0, 16'h00AA);
        step();
        rst_n = 1'b0;
        #1;
        chk("rstmid_ready", 32'(cmdReady), 32'd1);
        chk("rstmid_depth", 32'(depth), 32'd0);
        chk("rstmid_esact", 32'(ESAct), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rstmid_no_strobe", 32'(ESAct), 32'd0);
        end
        chk("rstmid_depth_after", 32'(depth), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
